// File: rtl/rom_128x8_pkg.sv
// Shared definitions for the 128x8 constant lookup table.
// Latency: n/a (types, parameters and the content function only).
// Backpressure: n/a.
//
// Holds the geometry and the single source of truth for the table contents,
// so the RTL table and any golden model are built from the same rule.
package rom_128x8_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  // Content rule: ((a * 29) mod 256) XOR 0x5A.
  // 29 is odd, so the multiply is a bijection mod 256 and every word is distinct.
  localparam logic [DATA_W-1:0] ROM_MULT = 8'd29;
  localparam logic [DATA_W-1:0] ROM_MASK = 8'h5A;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] prod;
    // 8-bit operands in an 8-bit context: the product truncates to the low byte.
    prod = {1'b0, a} * ROM_MULT;
    return prod ^ ROM_MASK;
  endfunction

endpackage

// File: rtl/rom_128x8.sv
// 128-word x 8-bit read-only lookup table with a registered read port.
// Latency: 1 cycle from the address-sample edge to valid data; data holds between edges.
// Backpressure: none (no enable or handshake; a new word is read every cycle).
//
// Ports:
//   clk      - single clock, rising-edge
//   rst      - synchronous active-high reset; forces data to 8'h00 and wins over a read
//   address  - 7-bit word address, sampled on the rising edge
//   data     - 8-bit registered read data
module rom_128x8
  import rom_128x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  // Constant table elaborated from the package content rule; synthesis folds
  // each entry to a constant, leaving a pure decode feeding the output register.
  logic [DATA_W-1:0] rom_table [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom_table[g] = rom_word(ADDR_W'(g));
  end

  // The full 7-bit address range maps onto the 128 entries, so no range check
  // or wrap logic is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= rom_table[address];
    end
  end

endmodule

// File: tb/tb_rom_128x8.sv
// Self-checking bench for rom_128x8: reset, spot values, full sweep, hold,
// mid-run reset and randomized reads against an arithmetic reference model.
// Inputs are driven on the falling edge; data is sampled 1 time unit after the rising edge.
module tb_rom_128x8;

  logic       clk;
  logic       rst;
  logic [6:0] address;
  logic [7:0] data;

  int total = 0;
  int bad   = 0;

  rom_128x8 dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the content rule.
  function automatic logic [7:0] ref_word(input int a);
    int v;
    v = ((a * 29) % 256) ^ 90;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply address/rst on the falling edge, then check just after the next rising edge.
  task automatic step(input string tag, input int a, input logic r, input logic [7:0] exp);
    @(negedge clk);
    address = a[6:0];
    rst     = r;
    @(posedge clk);
    #1;
    chk(tag, data, exp);
  endtask

  bit seen [256];
  int distinct;
  int a;
  logic r;

  initial begin
    rst     = 1'b1;
    address = 7'd5;

    // Reset held for two edges with address 5.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset", data, 8'h00);
    end
    // First edge after release loads ROM[5] (0x91 ^ 0x5A = 0xCB).
    step("rst_release", 5, 1'b0, ref_word(5));

    // Spot values.
    step("spot0",   0,   1'b0, 8'h5A);
    step("spot1",   1,   1'b0, 8'h47);
    step("spot64",  64,  1'b0, 8'h1A);
    step("spot127", 127, 1'b0, 8'h39);

    // Full sweep; collect observed words to confirm all 128 are distinct.
    distinct = 0;
    for (int i = 0; i < 128; i++) begin
      step("sweep", i, 1'b0, ref_word(i));
      if (!seen[data]) begin
        seen[data] = 1'b1;
        distinct++;
      end
    end
    total++;
    if (distinct != 128) begin
      bad++;
      $display("FAIL distinct: got %0d expected 128", distinct);
    end

    // Hold: address changes mid-cycle must not reach data before the next edge.
    step("hold_a3", 3, 1'b0, ref_word(3));
    #2;
    address = 7'd4;
    #1;
    chk("hold_mid", data, ref_word(3));
    @(negedge clk);
    chk("hold_neg", data, ref_word(3));
    @(posedge clk);
    #1;
    chk("hold_a4", data, ref_word(4));

    // Reset mid-run wins over the read; no recovery cycle afterwards.
    step("mid_rst", 40, 1'b1, 8'h00);
    step("post_rst", 41, 1'b0, ref_word(41));

    // Repeated reads of one address.
    repeat (3) step("repeat", 77, 1'b0, ref_word(77));

    // Randomized reads with occasional reset and mid-cycle address glitches.
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(127);
      r = ($urandom_range(15) == 0);
      step("rand", a, r, r ? 8'h00 : ref_word(a));
      if ($urandom_range(3) == 0) begin
        #2;
        address = 7'($urandom_range(127));
        #1;
        chk("rand_hold", data, r ? 8'h00 : ref_word(a));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
